// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read arbiter: FSM state encoding and
// default parameter values.
package fifo_read_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_ID_SZ     = 2;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_CNT_SZ    = 4;

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Read-side bundle between the arbiter and the FIFOs / shared output port.
// The arbiter uses the master view; the FIFO side uses the slave view.
interface fifo_read_arbiter_if
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_SZ   = DEF_ID_SZ
);

  logic [NUM_REQ-1:0] rempty;
  logic               out_ready;
  logic [NUM_REQ-1:0] rinc;
  logic [NUM_REQ-1:0] grant;
  logic [ID_SZ-1:0]   grant_id;
  logic               out_valid;

  modport master (
    input  rempty, out_ready,
    output rinc, grant, grant_id, out_valid
  );

  modport slave (
    output rempty, out_ready,
    input  rinc, grant, grant_id, out_valid
  );

endinterface

// File: rtl/fifo_read_arbiter_rr_pick.sv
// Rotating first-non-empty search: starting at rr_ptr and wrapping, returns
// the first FIFO whose empty flag is low as one-hot and binary index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_SZ   = 2
) (
  input  logic [NUM_REQ-1:0] rempty,
  input  logic [ID_SZ-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick_oh,
  output logic [ID_SZ-1:0]   pick_id,
  output logic               found
);

  int               sum;
  logic [ID_SZ-1:0] idx;

  always_comb begin
    pick_oh = '0;
    pick_id = '0;
    found   = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = ID_SZ'(sum);
      if (!found && !rempty[idx]) begin
        found        = 1'b1;
        pick_id      = idx;
        pick_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter granting one FIFO read side at a time onto a shared output.
// Define FIFO_ARB_BURST_EN for multi-read bursts; otherwise each grant reads once.
module fifo_read_arbiter
  import fifo_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int ID_SZ     = DEF_ID_SZ,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int CNT_SZ    = DEF_CNT_SZ
) (
  input logic                clk,
  input logic                rst,
  fifo_read_arbiter_if.master bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_SZ != $clog2(NUM_REQ) ||
      BURST_LEN < 1 || BURST_LEN > 15 || CNT_SZ < $clog2(BURST_LEN + 1)) begin : g_param_check
    $error("fifo_read_arbiter: parameter out of range");
  end

  arb_state_t         state;
  logic [NUM_REQ-1:0] grant_q;
  logic [ID_SZ-1:0]   grant_id_q;
  logic [ID_SZ-1:0]   rr_ptr;
  logic [ID_SZ-1:0]   next_ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_SZ-1:0]   pick_id;
  logic               found;
  logic               owner_empty;
  logic               read_ok;
  logic               last_read;
  logic [NUM_REQ-1:0] rinc;
  logic               out_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_SZ   (ID_SZ)
  ) u_rr_pick (
    .rempty  (bus.rempty),
    .rr_ptr  (rr_ptr),
    .pick_oh (pick_oh),
    .pick_id (pick_id),
    .found   (found)
  );

  // Reads follow out_ready in the same cycle; grant is one-hot so rinc is too.
  assign owner_empty = bus.rempty[grant_id_q];
  assign read_ok     = (state == GRANT) && bus.out_ready && !owner_empty;
  assign rinc        = read_ok ? grant_q : '0;
  assign out_valid   = |rinc;
  assign next_ptr    = (grant_id_q == ID_SZ'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_SZ'(1);

  assign bus.rinc      = rinc;
  assign bus.out_valid = out_valid;
  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;

`ifdef FIFO_ARB_BURST_EN
  logic [CNT_SZ-1:0] burst_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt <= '0;
    end else if (state != GRANT) begin
      burst_cnt <= '0;
    end else if (out_valid) begin
      burst_cnt <= burst_cnt + CNT_SZ'(1);
    end
  end

  assign last_read = out_valid && (burst_cnt == CNT_SZ'(BURST_LEN - 1));
`else
  assign last_read = out_valid;
`endif

  // Grant and grant_id clear when leaving GRANT so RELEASE shows no owner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      rr_ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state      <= GRANT;
            grant_q    <= pick_oh;
            grant_id_q <= pick_id;
          end
        end
        GRANT: begin
          if (last_read || owner_empty) begin
            state      <= RELEASE;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr     <= next_ptr;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Directed bench for fifo_read_arbiter: a word-count model per FIFO drives the
// empty flags, and per-cycle grant/rinc expectations are checked by hand.
module tb_fifo_read_arbiter;

`ifdef FIFO_ARB_BURST_EN
  localparam int EB = 4;
`else
  localparam int EB = 1;
`endif

  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;
  int words [4];

  logic [3:0] s_grant;
  logic [3:0] s_rinc;
  logic [1:0] s_id;
  logic       s_valid;

  fifo_read_arbiter_if #(.NUM_REQ(4), .ID_SZ(2)) bus ();

  fifo_read_arbiter #(
    .NUM_REQ   (4),
    .ID_SZ     (2),
    .BURST_LEN (4),
    .CNT_SZ    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic refreshEmpty();
    for (int i = 0; i < 4; i++) bus.rempty[i] = (words[i] == 0);
  endtask

  task automatic setWords(input int w0, input int w1, input int w2, input int w3);
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    words[3] = w3;
    refreshEmpty();
  endtask

  // One clock cycle: sample outputs mid-cycle, then retire the words read at the edge.
  task automatic applyStimulus(input logic ready);
    bus.out_ready = ready;
    @(negedge clk);
    s_grant = bus.grant;
    s_rinc  = bus.rinc;
    s_id    = bus.grant_id;
    s_valid = bus.out_valid;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (s_rinc[i] && words[i] > 0) words[i]--;
    refreshEmpty();
  endtask

  task automatic doReset(input string tag);
    rst = 1'b0;
    refreshEmpty();
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1);
      checkOutput({tag, "_rst_grant"}, 32'(s_grant), 32'h0);
      checkOutput({tag, "_rst_rinc"}, 32'(s_rinc), 32'h0);
      checkOutput({tag, "_rst_valid"}, 32'(s_valid), 32'h0);
      checkOutput({tag, "_rst_id"}, 32'(s_id), 32'h0);
    end
    rst = 1'b1;
  endtask

  // Full grant from IDLE: idle bubble, min(words,EB) reads, an extra held cycle
  // when the FIFO drains before the burst limit, then the release bubble.
  task automatic expectGrant(input string tag, input int id);
    int         n;
    bit         extra;
    logic [3:0] oh;
    oh    = 4'b0001 << id;
    n     = (words[id] < EB) ? words[id] : EB;
    extra = (words[id] < EB);
    applyStimulus(1'b1);
    checkOutput({tag, "_idle_grant"}, 32'(s_grant), 32'h0);
    checkOutput({tag, "_idle_rinc"}, 32'(s_rinc), 32'h0);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1);
      checkOutput({tag, "_grant"}, 32'(s_grant), 32'(oh));
      checkOutput({tag, "_id"}, 32'(s_id), 32'(id));
      checkOutput({tag, "_rinc"}, 32'(s_rinc), 32'(oh));
      checkOutput({tag, "_valid"}, 32'(s_valid), 32'h1);
    end
    if (extra) begin
      applyStimulus(1'b1);
      checkOutput({tag, "_drain_grant"}, 32'(s_grant), 32'(oh));
      checkOutput({tag, "_drain_rinc"}, 32'(s_rinc), 32'h0);
    end
    applyStimulus(1'b1);
    checkOutput({tag, "_rel_grant"}, 32'(s_grant), 32'h0);
    checkOutput({tag, "_rel_rinc"}, 32'(s_rinc), 32'h0);
    checkOutput({tag, "_rel_id"}, 32'(s_id), 32'h0);
  endtask

  initial begin
    int k;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    setWords(0, 0, 0, 0);

    // Reset with every FIFO non-empty, then fair rotation 0,1,2,3,0.
    setWords(100, 100, 100, 100);
    doReset("reset");
    expectGrant("fair0", 0);
    expectGrant("fair1", 1);
    expectGrant("fair2", 2);
    expectGrant("fair3", 3);
    expectGrant("fair0b", 0);

    // Single requester with 10 words is regranted after the two-cycle gap.
    setWords(0, 0, 10, 0);
    doReset("burst");
    expectGrant("burst_a", 2);
    expectGrant("burst_b", 2);

    // Early empty on FIFO 1 must leave the pointer at 2, not back at 0.
    setWords(1, 2, 5, 5);
    doReset("early");
    expectGrant("early0", 0);
    expectGrant("early1", 1);
    words[0] = 3;
    refreshEmpty();
    expectGrant("early2", 2);
    expectGrant("early3", 3);
    expectGrant("early0b", 0);

    // Backpressure mid-burst: grant holds, no reads, count resumes after.
    setWords(0, 0, 0, 20);
    doReset("bp");
    applyStimulus(1'b1);
    checkOutput("bp_idle_grant", 32'(s_grant), 32'h0);
    k = EB / 2;
    for (int i = 0; i < k; i++) begin
      applyStimulus(1'b1);
      checkOutput("bp_pre_rinc", 32'(s_rinc), 32'h8);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      checkOutput("bp_stall_grant", 32'(s_grant), 32'h8);
      checkOutput("bp_stall_id", 32'(s_id), 32'h3);
      checkOutput("bp_stall_rinc", 32'(s_rinc), 32'h0);
      checkOutput("bp_stall_valid", 32'(s_valid), 32'h0);
    end
    for (int i = k; i < EB; i++) begin
      applyStimulus(1'b1);
      checkOutput("bp_post_rinc", 32'(s_rinc), 32'h8);
    end
    applyStimulus(1'b1);
    checkOutput("bp_rel_grant", 32'(s_grant), 32'h0);
    checkOutput("bp_rel_rinc", 32'(s_rinc), 32'h0);

    // Asynchronous reset between edges while FIFO 2 owns the output.
    setWords(0, 0, 20, 0);
    doReset("async");
    expectGrant("async_pre", 2);
    applyStimulus(1'b1);
    checkOutput("async_idle_grant", 32'(s_grant), 32'h0);
    #1;
    checkOutput("async_pre_rinc", 32'(bus.rinc), 32'h4);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_grant", 32'(bus.grant), 32'h0);
    checkOutput("async_rinc", 32'(bus.rinc), 32'h0);
    checkOutput("async_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("async_id", 32'(bus.grant_id), 32'h0);
    words[0] = 20;
    words[3] = 20;
    refreshEmpty();
    applyStimulus(1'b1);
    checkOutput("async_hold_rinc", 32'(s_rinc), 32'h0);
    rst = 1'b1;
    expectGrant("async_post", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
